// File: rtl/db_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : db_mem_arbiter
//  Purpose  : Sequences debugger memory/register commands onto the MCU's
//             shared data-memory and register-file ports. The CPU passes
//             through to memory when no debugger access is in flight.
//  Revision : 1.0  initial release
// ============================================================================
module db_mem_arbiter #(
   parameter int MEM_WORDS = 64,
   parameter int RF_SIZE   = 32,
   parameter int TIMEOUT   = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   // debugger command side
   input  logic        db_valid,
   input  logic        db_mem_rd,
   input  logic        db_mem_wr,
   input  logic        db_reg_rd,
   input  logic        db_reg_wr,
   input  logic [31:0] db_addr,
   input  logic [31:0] db_d_in,
   input  logic [3:0]  db_mem_be,
   output logic        db_busy,
   output logic        db_done,
   output logic        db_error,
   output logic [31:0] db_d_rd,
   // CPU side
   input  logic        cpu_paused,
   input  logic        cpu_mem_rd,
   input  logic        cpu_mem_wr,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_din,
   input  logic [3:0]  cpu_be,
   output logic        cpu_stall,
   // shared data-memory port
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_din,
   output logic [3:0]  mem_be,
   input  logic [31:0] mem_dout,
   input  logic        mem_ready,
   // register-file port
   output logic        rf_we,
   output logic [4:0]  rf_addr,
   output logic [31:0] rf_din,
   input  logic [31:0] rf_dout
);

   localparam logic [1:0] C_IDLE = 2'd0;
   localparam logic [1:0] C_MEM  = 2'd1;
   localparam logic [1:0] C_REG  = 2'd2;
   localparam logic [1:0] C_DONE = 2'd3;

   // Command op vector bit positions: {reg_wr, reg_rd, mem_wr, mem_rd}
   localparam int C_OP_MRD = 0;
   localparam int C_OP_MWR = 1;
   localparam int C_OP_RRD = 2;
   localparam int C_OP_RWR = 3;

   localparam int              CW         = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]   C_CNT_LAST = CW'(TIMEOUT - 1);
   localparam logic [31:0]     C_MEM_LIM  = 32'(MEM_WORDS);
   localparam logic [31:0]     C_RF_LIM   = 32'(RF_SIZE);

   logic [1:0]    r_state;
   logic [3:0]    r_op;
   logic [31:0]   r_addr;
   logic [31:0]   r_din;
   logic [3:0]    r_be;
   logic          r_err;
   logic [CW-1:0] r_cnt;
   logic [31:0]   r_d_rd;

   logic [3:0]    w_op;
   logic          w_multi;
   logic          w_is_mem;
   logic          w_is_reg;
   logic          w_bad;
   logic [1:0]    w_accept_state;

   // Decode and validate the incoming command (only used when accepted in IDLE)
   always_comb begin
      w_op     = {db_reg_wr, db_reg_rd, db_mem_wr, db_mem_rd};
      // more than one op bit set: clearing the lowest set bit leaves something
      w_multi  = |(w_op & (w_op - 4'd1));
      w_is_mem = w_op[C_OP_MRD] | w_op[C_OP_MWR];
      w_is_reg = w_op[C_OP_RRD] | w_op[C_OP_RWR];
      w_bad    = w_multi
               | (w_is_mem & (db_addr >= C_MEM_LIM))
               | (w_is_reg & ((db_addr >= C_RF_LIM) | ~cpu_paused));
      if (w_bad || (w_op == 4'd0))
         w_accept_state = C_DONE;
      else if (w_is_mem)
         w_accept_state = C_MEM;
      else
         w_accept_state = C_REG;
   end

   // Command sequencer: accept/validate, memory handshake with timeout, completion
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= C_IDLE;
         r_op    <= 4'd0;
         r_addr  <= 32'd0;
         r_din   <= 32'd0;
         r_be    <= 4'd0;
         r_err   <= 1'b0;
         r_cnt   <= '0;
         r_d_rd  <= 32'd0;
      end else begin
         case (r_state)
            C_IDLE: begin
               if (db_valid) begin
                  r_op    <= w_op;
                  r_addr  <= db_addr;
                  r_din   <= db_d_in;
                  r_be    <= db_mem_be;
                  r_err   <= w_bad;
                  r_cnt   <= '0;
                  r_state <= w_accept_state;
               end
            end
            C_MEM: begin
               // ready takes priority over an expiring timeout in the same cycle
               if (mem_ready) begin
                  if (r_op[C_OP_MRD])
                     r_d_rd <= mem_dout;
                  r_state <= C_DONE;
               end else if (r_cnt == C_CNT_LAST) begin
                  r_err   <= 1'b1;
                  r_state <= C_DONE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            C_REG: begin
               if (r_op[C_OP_RRD])
                  r_d_rd <= rf_dout;
               r_state <= C_DONE;
            end
            default: begin
               r_state <= C_IDLE;
            end
         endcase
      end
   end

   // Memory port mux: debugger owns the port only while in MEM, CPU is held off then
   always_comb begin
      if (r_state == C_MEM) begin
         mem_rd    = r_op[C_OP_MRD];
         mem_wr    = r_op[C_OP_MWR];
         mem_addr  = r_addr;
         mem_din   = r_din;
         mem_be    = r_be;
         cpu_stall = 1'b1;
      end else begin
         mem_rd    = cpu_mem_rd;
         mem_wr    = cpu_mem_wr;
         mem_addr  = cpu_addr;
         mem_din   = cpu_din;
         mem_be    = cpu_be;
         cpu_stall = 1'b0;
      end
   end

   // Register-file port and debugger status outputs; writes to x0 are dropped silently
   always_comb begin
      rf_addr  = r_addr[4:0];
      rf_din   = r_din;
      rf_we    = (r_state == C_REG) && r_op[C_OP_RWR] && (r_addr != 32'd0);
      db_busy  = (r_state != C_IDLE);
      db_done  = (r_state == C_DONE);
      db_error = (r_state == C_DONE) && r_err;
      db_d_rd  = r_d_rd;
   end

endmodule
`default_nettype wire
